alu_input_seq: RTL and testbench
================================

# alu_input_seq

Operand and command sequencer that sits directly upstream of the combinational 4-bit ALU. It turns a bank of board switches and a single "next" push-button into a stable operand A, operand B and operation word, loaded in three successive presses. It then presents them to the ALU together with a `valid` flag. The button input is synchronized and, optionally, debounced, so that each physical press advances the sequence exactly once.

## Interface
Parameters:
- `N`, default 4: operand width; must be ≥ 4, because the operation word is taken from `sw[3:0]`.
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-high cycles required to accept a press; must be ≥ 1.

Ports:
- `clk`  in  1: single clock; all state is updated on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `sw`  in  N: switch bank, sampled when a press is accepted.
- `btn_next`  in  1: asynchronous push-button that advances the sequence.
- `btn_clear`  in  1: asynchronous clear request; level-sensitive after synchronization.
- `a`  out  N: registered operand A, drives the ALU `a` input.
- `b`  out  N: registered operand B, drives the ALU `b` input.
- `op`  out  3: registered logic-op select.
- `op_sum`  out  1: registered add select.
- `op_subt`  out  1: registered subtract select.
- `valid`  out  1: high only in state EXEC.
- `state`  out  2: current FSM state, for LEDs and debug.

## Operation
- **Synchronizers:** `btn_next` and `btn_clear` each pass through a 2-flop synchronizer, giving `nxt_s` and `clr_s`.
- **Press accept:** a pulse `accept` is generated once per press (see Configuration). It is never repeated while the button is held.
- **FSM states:** LOAD_A = 0, LOAD_B = 1, LOAD_OP = 2, EXEC = 3.
- **Transitions on `accept`:**
  - LOAD_A → LOAD_B, with `a <= sw`.
  - LOAD_B → LOAD_OP, with `b <= sw`.
  - LOAD_OP → EXEC, with:
    - `op <= sw[2:0]`
    - `op_sum <= sw[3] & ~sw[0]`
    - `op_subt <= sw[3] & sw[0]`
  - EXEC → LOAD_A. Registers hold their values; `valid` drops.
- **Mutual exclusion:** `op_sum` and `op_subt` are never both 1.
- **Clear:** while `clr_s` = 1:
  - the state is forced to LOAD_A;
  - `a`, `b`, `op`, `op_sum` and `op_subt` are forced to 0;
  - the debounce counter is forced to 0;
  - `accept` is suppressed. Clear has priority over a simultaneous accept.
- **Reset:** asserting `rst` at any time, including mid-debounce or in EXEC, immediately sets every output to 0:
  - `a`, `b` = 0; `op` = 0; `op_sum`, `op_subt` = 0;
  - `valid` = 0; `state` = LOAD_A (0);
  - synchronizer flops and the counter are cleared.
- **Switch changes:** `sw` changes outside an accept cycle have no effect on the outputs.

## Timing
- All outputs are registered. `valid` is decoded from the state register and is asserted the cycle after the LOAD_OP → EXEC edge.
- **Accept latency:** `btn_next` is high before clock edge k and stays high. The state and capture update at edge k+1+DEBOUNCE_CYCLES. With the default of 4, this is edge k+5.
- **Without debounce:** the update occurs at edge k+2.
- **Bounce rejection:** a high pulse on `nxt_s` shorter than DEBOUNCE_CYCLES cycles produces no accept. The counter returns to 0 on any low cycle.
- **Clear latency:** `btn_clear` high before edge k takes effect at edge k+2. Outputs are 0 from that edge onward while it is held.
- **Wrap-around:** after EXEC, the next accept wraps to LOAD_A. No other wrap exists.

## Configuration
- **Macro:** `ALU_SEQ_DEBOUNCE_EN`.
- **Defined:** a saturating counter of width `$clog2(DEBOUNCE_CYCLES+1)` increments each cycle `nxt_s` = 1 and resets to 0 when `nxt_s` = 0. `accept` = `nxt_s` & (count == DEBOUNCE_CYCLES-1).
- **Undefined:** no counter. `accept` = `nxt_s` & ~`nxt_s_d`, a rising-edge detect with one extra flop. `DEBOUNCE_CYCLES` is ignored.

## Test plan
- **Reset:** assert `rst` mid-operation, asynchronously between edges → all outputs read 0 immediately, `state` = 0.
- **Full sequence, debounce on, D = 4, N = 4:**
  - stimulus: three 6-cycle presses with `sw` = 4'b0101, then 4'b0011, then 4'b1000;
  - response: `a` = 5, `b` = 3, `op_sum` = 1, `op_subt` = 0, `op` = 3'b000;
  - `state` = 3 and `valid` = 1 after the third press.
- **Subtract decode:** third press with `sw` = 4'b1001 → `op_subt` = 1, `op_sum` = 0, `op` = 3'b001.
- **Bounce:** 3-cycle pulse on `btn_next` with D = 4 → no state change. A following 5-cycle pulse advances exactly one state. Holding the button for 50 cycles advances exactly one state.
- **Clear vs next:** in LOAD_OP, assert `btn_clear` and `btn_next` together → `state` = 0, `a` = `b` = 0, and no capture occurs.
- **Wrap and compile variant:** in EXEC, one press gives `state` = 0, `valid` = 0, and `a`/`b` retained. Build without `ALU_SEQ_DEBOUNCE_EN` → a press sampled before edge k updates at edge k+2.

Source files
------------

// File: rtl/alu_input_seq.sv
// Purpose : operand/command sequencer in front of the 4-bit combinational ALU.
//           Three button presses load A, B and the op word from the switch bank,
//           then the values are presented to the ALU with 'valid'.
// Latency : a press is applied 2 edges after btn_next rises when debounce is off.
//           With debounce on, it is applied 1+DEBOUNCE_CYCLES edges after.
//           Clear takes effect 2 edges after btn_clear rises.
// Backpressure: none. One accept per physical press, and a held button never repeats.
//
// Build option: define ALU_SEQ_DEBOUNCE_EN to add a saturating press debouncer.
//   Without it, a press is a rising-edge detect on the synchronized button.
//
// Ports:
//   clk        in  1   single rising-edge clock
//   rst        in  1   asynchronous active-high reset
//   sw         in  N   switch bank, captured on an accepted press
//   btn_next   in  1   asynchronous "next" push-button
//   btn_clear  in  1   asynchronous clear, level-sensitive once synchronized
//   a, b       out N   registered operands
//   op         out 3   registered logic-op select (sw[2:0])
//   op_sum     out 1   registered add select      (sw[3] & ~sw[0])
//   op_subt    out 1   registered subtract select (sw[3] &  sw[0])
//   valid      out 1   high only in EXEC
//   state      out 2   current sequencer state (LOAD_A=0 .. EXEC=3)

module alu_input_seq #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic         btn_next,
  input  logic         btn_clear,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [2:0]   op,
  output logic         op_sum,
  output logic         op_subt,
  output logic         valid,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    EXEC    = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers for both asynchronous buttons
  // ---------------------------------------------------------------------------
  logic [1:0] nxt_sync_q;
  logic [1:0] clr_sync_q;
  logic       nxt_s;
  logic       clr_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt_sync_q <= 2'b00;
      clr_sync_q <= 2'b00;
    end else begin
      nxt_sync_q <= {nxt_sync_q[0], btn_next};
      clr_sync_q <= {clr_sync_q[0], btn_clear};
    end
  end

  assign nxt_s = nxt_sync_q[1];
  assign clr_s = clr_sync_q[1];

  // ---------------------------------------------------------------------------
  // Press accept: exactly one single-cycle pulse per physical press
  // ---------------------------------------------------------------------------
  logic accept;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_HIT = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter saturates at DEBOUNCE_CYCLES, one past the accept value.
  // A held button therefore matches CNT_HIT only once.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_s || !nxt_s) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign accept = nxt_s & ~clr_s & (cnt_q == CNT_HIT);
`else
  logic nxt_s_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt_s_d_q <= 1'b0;
    end else begin
      nxt_s_d_q <= nxt_s;
    end
  end

  // Rising-edge detect. Clear has priority, so it masks an accept in the same cycle.
  assign accept = nxt_s & ~nxt_s_d_q & ~clr_s;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM and capture registers
  // ---------------------------------------------------------------------------
  state_e       state_q,   state_d;
  logic [N-1:0] a_q,       a_d;
  logic [N-1:0] b_q,       b_d;
  logic [2:0]   op_q,      op_d;
  logic         op_sum_q,  op_sum_d;
  logic         op_subt_q, op_subt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 3'b000;
      op_sum_q  <= 1'b0;
      op_subt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      op_sum_q  <= op_sum_d;
      op_subt_q <= op_subt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    op_sum_d  = op_sum_q;
    op_subt_d = op_subt_q;

    if (clr_s) begin
      state_d   = LOAD_A;
      a_d       = '0;
      b_d       = '0;
      op_d      = 3'b000;
      op_sum_d  = 1'b0;
      op_subt_d = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        LOAD_A: begin
          a_d     = sw;
          state_d = LOAD_B;
        end
        LOAD_B: begin
          b_d     = sw;
          state_d = LOAD_OP;
        end
        LOAD_OP: begin
          // sw[0] selects between add and subtract when sw[3] is set.
          // This keeps op_sum and op_subt mutually exclusive.
          op_d      = sw[2:0];
          op_sum_d  = sw[3] & ~sw[0];
          op_subt_d = sw[3] &  sw[0];
          state_d   = EXEC;
        end
        EXEC: begin
          // Operands are kept so they stay visible after leaving EXEC.
          state_d = LOAD_A;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign op      = op_q;
  assign op_sum  = op_sum_q;
  assign op_subt = op_subt_q;
  assign state   = state_q;
  assign valid   = (state_q == EXEC);

  a_op_excl: assert property (@(posedge clk) disable iff (rst) !(op_sum_q && op_subt_q));

endmodule

// File: tb/tb_alu_input_seq.sv
`timescale 1ns/1ps

module tb_alu_input_seq;

  localparam int N = 4;
  localparam int D = 4;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int MIN_HOLD = D;      // shortest press that is accepted
  localparam int EXP_LAT  = D + 2;  // edges counted from edge k (=1) to the update edge k+1+D
`else
  localparam int MIN_HOLD = 1;
  localparam int EXP_LAT  = 3;      // update at edge k+2
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw = '0;
  logic         btn_next = 1'b0;
  logic         btn_clear = 1'b0;
  logic [N-1:0] a, b;
  logic [2:0]   op;
  logic         op_sum, op_subt, valid;
  logic [1:0]   state;

  always #5 clk = ~clk;

  alu_input_seq #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_next  (btn_next),
    .btn_clear (btn_clear),
    .a         (a),
    .b         (b),
    .op        (op),
    .op_sum    (op_sum),
    .op_subt   (op_subt),
    .valid     (valid),
    .state     (state)
  );

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       sum;
    logic       subt;
    logic       vld;
    logic [1:0] st;
  } exp_t;

  exp_t sb_q[$];

  // Reference model of the visible registers
  logic [3:0] m_a = '0, m_b = '0;
  logic [2:0] m_op = '0;
  logic       m_sum = 1'b0, m_subt = 1'b0;
  logic [1:0] m_st = 2'd0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_now();
    exp_t e;
    e.a    = m_a;
    e.b    = m_b;
    e.op   = m_op;
    e.sum  = m_sum;
    e.subt = m_subt;
    e.vld  = (m_st == 2'd3);
    e.st   = m_st;
    return e;
  endfunction

  task automatic model_zero();
    m_a = '0; m_b = '0; m_op = '0; m_sum = 1'b0; m_subt = 1'b0; m_st = 2'd0;
  endtask

  task automatic model_accept(input logic [3:0] s);
    case (m_st)
      2'd0: begin m_a = s; m_st = 2'd1; end
      2'd1: begin m_b = s; m_st = 2'd2; end
      2'd2: begin
        m_op   = s[2:0];
        m_sum  = s[3] & ~s[0];
        m_subt = s[3] &  s[0];
        m_st   = 2'd3;
      end
      default: m_st = 2'd0;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    check_val({tag, ".a"},     32'(a),       32'(e.a));
    check_val({tag, ".b"},     32'(b),       32'(e.b));
    check_val({tag, ".op"},    32'(op),      32'(e.op));
    check_val({tag, ".sum"},   32'(op_sum),  32'(e.sum));
    check_val({tag, ".subt"},  32'(op_subt), 32'(e.subt));
    check_val({tag, ".valid"}, 32'(valid),   32'(e.vld));
    check_val({tag, ".state"}, 32'(state),   32'(e.st));
  endtask

  // Press btn_next with switches s for 'hold' clock edges, then release.
  // Measures how many state changes occur and when the first one happens.
  task automatic press(input string tag, input logic [3:0] s, input int hold);
    int         edges, changes, first;
    logic [1:0] prev;
    bit         acc;
    @(negedge clk);
    sw       = s;
    btn_next = 1'b1;
    acc = (hold >= MIN_HOLD);
    if (acc) model_accept(s);
    sb_q.push_back(model_now());
    prev = state; edges = 0; changes = 0; first = 0;
    for (int i = 0; i < hold + 10; i++) begin
      @(posedge clk); #1;
      edges++;
      if (state !== prev) begin
        changes++;
        if (first == 0) first = edges;
        prev = state;
      end
      if (edges == hold) begin
        @(negedge clk);
        btn_next = 1'b0;
      end
    end
    check_val({tag, ".nchg"}, changes, acc ? 1 : 0);
    if (acc) check_val({tag, ".lat"}, first, EXP_LAT);
    // Switch activity outside an accept must not reach the outputs.
    sw = ~s;
    repeat (3) @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive_to(input logic [1:0] target);
    for (int i = 0; i < 4; i++) begin
      if (m_st != target) press("walk", 4'h6, 6);
    end
  endtask

  task automatic clear_with_next();
    logic [1:0] old_st;
    old_st = state;
    @(negedge clk);
    btn_clear = 1'b1;
    btn_next  = 1'b1;
    sw        = 4'hF;
    model_zero();
    sb_q.push_back(model_now());
    repeat (2) @(posedge clk);
    #1;
    check_val("clr.early_state", 32'(state), 32'(old_st));
    @(posedge clk); #1;
    check_outputs("clr.k2");
    repeat (8) @(posedge clk);
    @(negedge clk);
    btn_clear = 1'b0;
    btn_next  = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    sb_q.push_back(model_now());
    check_outputs("clr.after");
  endtask

  // Assert rst between clock edges and check the outputs before any further edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    btn_next = 1'b0;
    #1;
    model_zero();
    sb_q.push_back(model_now());
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #12;
    model_zero();
    sb_q.push_back(model_now());
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Full add sequence
    press("ldA", 4'b0101, 6);
    press("ldB", 4'b0011, 6);
    press("ldOP_add", 4'b1000, 6);
    // Wrap from EXEC back to LOAD_A, operands held
    press("wrap1", 4'b1010, 6);

    // Subtract decode
    press("ldA2", 4'b0101, 6);
    press("ldB2", 4'b0011, 6);
    press("ldOP_sub", 4'b1001, 6);
    press("wrap2", 4'b0000, 6);

    // Short pulse, minimum pulse and long hold
    press("bounce3", 4'h7, 3);
    press("pulse5", 4'h7, 5);
    press("hold50", 4'h2, 50);

    // Clear together with next while in LOAD_OP
    drive_to(2'd2);
    clear_with_next();

    // Reset while in EXEC
    drive_to(2'd3);
    async_reset("rst_exec");
    repeat (3) @(posedge clk);

    // Reset in the middle of a press
    @(negedge clk);
    sw = 4'h5;
    btn_next = 1'b1;
    repeat (2) @(posedge clk);
    async_reset("rst_mid");
    repeat (8) @(posedge clk);
    #1;
    sb_q.push_back(model_now());
    check_outputs("rst_mid.after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
